// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer.
// Latency: none (types, constants and one pure function).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the RV32I major opcodes, the datapath mux
// encodings (pc_src, wb_sel, alu_a_sel, alu_b_sel) and the trap cause codes.
package rv32i_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // pc_src encoding
    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    // wb_sel encoding
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // ALU operand select encodings
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

    // trap_cause encoding
    localparam logic [1:0] TRAP_NONE        = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'd1;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;
    localparam logic [1:0] TRAP_ENV         = 2'd3;

    // True for every opcode the sequencer knows how to step (SYSTEM included;
    // it is routed to TRAP separately).
    function automatic logic is_known_opcode(input logic [6:0] op);
        logic known;
        case (op)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
            default:                                   known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/rv32i_mem_wait.sv
// Memory wait counter with timeout compare for the shared memory port.
// Latency: timeout is combinational from the registered count and mem_ready.
// Backpressure: counts while count_en is high and mem_ready is low.
//
// Ports: clk, rst_n (async active-low), clear (state change), count_en
// (FETCH/MEM), mem_ready, timeout (count reached MEM_TIMEOUT with no ready).
module rv32i_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] wait_cnt;

    // clear has priority: the counter restarts on every state change,
    // including the transition out of a timed-out wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (clear) begin
            wait_cnt <= 8'd0;
        end else if (count_en && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A ready in the same cycle as the limit completes normally.
    assign timeout = count_en && !mem_ready && (wait_cnt == LIMIT);

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port.
// Latency: 3 cycles branch/jump, 4 ALU/store, 5 load (zero-wait memory).
// Backpressure: FETCH/MEM stall on mem_ready=0; trap after MEM_TIMEOUT wait cycles.
//
// Ports: clk, rst_n (async active-low); opcode, br_taken, mem_ready in;
// memory controls (mem_req/mem_we/mem_addr_sel), datapath enables and selects
// (ir_we, pc_we, pc_src, rf_we, wb_sel, alu_a_sel, alu_b_sel), retired pulse,
// trap/trap_cause and state_o out.
// Optional macro RV_MC_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module rv32i_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        retired,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_o
`ifdef RV_MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    import rv32i_ctrl_pkg::*;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] trap_cause_nxt;
    logic       wait_clr;
    logic       wait_en;
    logic       timeout;
    logic [1:0] op_a_sel;
    logic       op_b_sel;
    logic       is_load;
    logic       is_store;

    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign state_o  = state;

    assign wait_en  = (state == ST_FETCH) || (state == ST_MEM);
    assign wait_clr = (state_nxt != state);

    rv32i_mem_wait #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (wait_clr),
        .count_en  (wait_en),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // State register; trap_cause only changes on the way into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            trap_cause <= TRAP_NONE;
        end else begin
            state      <= state_nxt;
            trap_cause <= trap_cause_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        trap_cause_nxt = trap_cause;
        case (state)
            ST_RST: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_nxt = ST_DECODE;
                end else if (timeout) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = TRAP_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opcode == OPC_SYSTEM) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = TRAP_ENV;
                end else if (TRAP_ON_ILLEGAL && !is_known_opcode(opcode)) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = TRAP_ILLEGAL;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_nxt = ST_WB;
                    OPC_LOAD, OPC_STORE:                    state_nxt = ST_MEM;
                    default:                                state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_nxt = is_store ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = TRAP_MEM_TIMEOUT;
                end
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_RST;
        endcase
    end

    // ALU operand selects implied by the opcode; driven in EXEC and held
    // through MEM/WB so the ALU result stays valid as an address or result.
    always_comb begin
        op_a_sel = ALU_A_RS1;
        op_b_sel = ALU_B_RS2;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: op_b_sel = ALU_B_IMM;
            OPC_LUI: begin
                op_a_sel = ALU_A_ZERO;
                op_b_sel = ALU_B_IMM;
            end
            OPC_AUIPC: begin
                op_a_sel = ALU_A_PC;
                op_b_sel = ALU_B_IMM;
            end
            default: ;
        endcase
    end

    // Output decode (Mealy on mem_ready in FETCH/MEM, br_taken in EXEC)
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        rf_we        = 1'b0;
        wb_sel       = WB_SEL_ALU;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        retired      = 1'b0;
        trap         = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                case (opcode)
                    OPC_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                        retired = 1'b1;
                    end
                    OPC_JAL: begin
                        rf_we   = 1'b1;
                        wb_sel  = WB_SEL_PC4;
                        pc_we   = 1'b1;
                        pc_src  = PC_SRC_IMM;
                        retired = 1'b1;
                    end
                    OPC_JALR: begin
                        rf_we   = 1'b1;
                        wb_sel  = WB_SEL_PC4;
                        pc_we   = 1'b1;
                        pc_src  = PC_SRC_ALU;
                        retired = 1'b1;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                    OPC_LOAD, OPC_STORE: ;
                    default: begin
                        // Unknown opcode retired as a NOP (only reachable
                        // when illegal opcodes do not trap).
                        pc_we   = 1'b1;
                        retired = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                alu_a_sel    = op_a_sel;
                alu_b_sel    = op_b_sel;
                if (is_store && mem_ready) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            ST_WB: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                rf_we     = 1'b1;
                wb_sel    = is_load ? WB_SEL_MEM : WB_SEL_ALU;
                pc_we     = 1'b1;
                retired   = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

`ifdef RV_MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != ST_RST) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retired) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and shares one memory port between instruction fetch and load/store. It drives the register-file, PC and IR enables and the datapath mux selects from the IR opcode. It sits between the instruction register/decoder and the ALU/regfile/memory datapath.

Parameters:
MEM_TIMEOUT, 15, wait cycles allowed on a memory request before trapping; legal range 1..255.
TRAP_ON_ILLEGAL, 1, 1 = an unknown opcode enters TRAP; 0 = it is treated as a NOP.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
br_taken  in  1  branch comparison result from ALU, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  store when 1
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared
rf_we  out  1  register-file write
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
alu_b_sel  out  1  0 = rs2, 1 = imm
retired  out  1  one-cycle pulse when an instruction completes
trap  out  1  high while in TRAP
trap_cause  out  2  0 = none, 1 = illegal, 2 = mem timeout, 3 = ecall/ebreak
state_o  out  3  current state, for debug

Behaviour:
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: while rst_n is low, state=RST, wait counter=0, trap_cause=0. Every output is 0 while in RST. RST always goes to FETCH on the next clock edge.
- Outputs are decoded from the state. ir_we, pc_we (on memory completion) and retired also depend on mem_ready and br_taken, so those are Mealy outputs.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir_we=1, go to DECODE.
  - Otherwise: stay in FETCH, wait counter increments.
- DECODE: no enables asserted. Next state is EXEC, or TRAP with cause 1 if the opcode is illegal and TRAP_ON_ILLEGAL=1. SYSTEM (1110011) goes to TRAP with cause 3.
- EXEC, by opcode:
  - OP (0110011): a=0, b=0 -> WB.
  - OP-IMM (0010011): a=0, b=1 -> WB.
  - LUI (0110111): a=2, b=1 -> WB.
  - AUIPC (0010111): a=1, b=1 -> WB.
  - LOAD (0000011) and STORE (0100011): a=0, b=1 -> MEM.
  - BRANCH (1100011): pc_we=1, pc_src = br_taken ? 1 : 0, retired=1 -> FETCH.
  - JAL (1101111): rf_we=1, wb_sel=2, pc_we=1, pc_src=1, retired=1 -> FETCH.
  - JALR (1100111): a=0, b=1, rf_we=1, wb_sel=2, pc_we=1, pc_src=2, retired=1 -> FETCH.
  - Illegal opcode with TRAP_ON_ILLEGAL=0: pc_we=1, pc_src=0, retired=1 -> FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. ALU select values are held at their EXEC values.
  - mem_ready=1 on STORE: pc_we=1, pc_src=0, retired=1 -> FETCH.
  - mem_ready=1 on LOAD: -> WB.
- WB: rf_we=1, wb_sel=1 for LOAD and 0 otherwise, pc_we=1, pc_src=0, retired=1 -> FETCH.
- Memory handshake:
  - mem_req, mem_we and mem_addr_sel are stable while waiting.
  - Completion happens on the first cycle with mem_ready=1, including the cycle mem_req first rises (zero-wait).
  - mem_ready outside FETCH/MEM is ignored.
- Wait counter: 8-bit. Cleared on every state change. Incremented in FETCH/MEM while mem_ready=0. If the counter equals MEM_TIMEOUT and mem_ready=0, go to TRAP with cause 2. mem_ready=1 in that same cycle wins: normal completion, no trap.
- TRAP: trap=1, all enables 0, trap_cause held. Only reset exits TRAP.
- Zero-wait latencies:
  - BRANCH, JAL, JALR: 3 cycles.
  - ALU, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronously); no partial write is allowed.

Optional Feature:
RV_MC_PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle not in RST.
  - instret_cnt increments on each retired pulse.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - the state encoding;
  - opcode constants;
  - the pc_src, wb_sel and alu_a_sel encodings;
  - the trap_cause encoding.
- Sub-module rv32i_mem_wait: the wait counter plus timeout compare. Inputs: clear, count enable, mem_ready. Output: timeout.

Test Plan:
- addi (0x00200113), zero-wait memory -> states 1,2,3,5,1; rf_we=1 and retired=1 in WB; 4 cycles.
- lw (0x00022203), mem_ready delayed 3 cycles in MEM -> mem_req and mem_addr_sel=1 held for 4 cycles; WB with wb_sel=1; retired after 8 cycles.
- beq with br_taken=1, then with br_taken=0 -> pc_src=1, then pc_src=0; pc_we=1 in EXEC; rf_we stays 0.
- jalr (0x06400167) -> in EXEC: rf_we=1, wb_sel=2, pc_src=2, pc_we=1 in the same cycle.
- mem_ready held at 0 in FETCH -> trap=1 and trap_cause=2 after 16 cycles in FETCH; mem_ready=1 on exactly cycle 16 -> no trap.
- Opcode 0x7F with TRAP_ON_ILLEGAL=1 -> TRAP, cause 1. rst_n pulsed low mid-MEM -> all outputs 0 immediately; FETCH one cycle after release.
